// File: rtl/dmem_access_unit.sv
// Load/store initiator for the word-wide Data_Memory. Sub-word stores use read-modify-write,
// and each request completes with a single-cycle response that carries the extended load data or an error.
module dmem_access_unit #(
    parameter int REG_BITS  = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [REG_BITS-1:0] req_addr,
    input  logic [REG_BITS-1:0] req_wdata,
    output logic                resp_valid,
    output logic [REG_BITS-1:0] resp_rdata,
    output logic                resp_err,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [REG_BITS-1:0] addr,
    output logic [REG_BITS-1:0] write_data,
    input  logic [REG_BITS-1:0] read_data
);

    // state  | meaning
    // IDLE   | ready for a request
    // RD     | memory read (load, or first half of a sub-word store)
    // WR     | memory write of the full word
    // RESP   | one-cycle response to the core
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [REG_BITS-3:0] MEM_WORDS_W = (REG_BITS-2)'(MEM_WORDS);

    state_t              state_q, state_d;
    logic                write_q, signed_q, err_q;
    logic [1:0]          size_q;
    logic [REG_BITS-1:0] addr_q, wdata_q, word_q;
    logic [REG_BITS-1:0] addr_hold_q, wdata_hold_q;

    logic                accept, req_err;
    logic [REG_BITS-1:0] merged, load_data;
    logic [7:0]          lane8;
    logic [15:0]         lane16;

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b11:   req_err = 1'b1;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b0;
        endcase
        if (req_addr[REG_BITS-1:2] >= MEM_WORDS_W)
            req_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = S_RESP;
                    else if (!req_write || req_size != 2'b10)
                        state_d = S_RD;
                    else
                        state_d = S_WR;
                end
            end
            S_RD:    state_d = write_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane merge for sub-word stores; a word store passes the request data straight through.
    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    assign lane8  = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign lane16 = word_q[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'b00:   load_data = signed_q ? {{(REG_BITS-8){lane8[7]}}, lane8}
                                          : {{(REG_BITS-8){1'b0}}, lane8};
            2'b01:   load_data = signed_q ? {{(REG_BITS-16){lane16[15]}}, lane16}
                                          : {{(REG_BITS-16){1'b0}}, lane16};
            default: load_data = word_q;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : '0;

    // Strobes are gated by reset so an aborted RMW never commits a write.
    assign MemRead    = (state_q == S_RD) && !reset;
    assign MemWrite   = (state_q == S_WR) && !reset;
    assign addr       = (state_q == S_RD || state_q == S_WR) ? {2'b00, addr_q[REG_BITS-1:2]}
                                                             : addr_hold_q;
    assign write_data = (state_q == S_WR) ? merged : wdata_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_q       <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_err;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state_q == S_RD)
                word_q <= read_data;
            if (MemRead || MemWrite)
                addr_hold_q <= addr;
            if (MemWrite)
                wdata_hold_q <= write_data;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios plus random traffic checked against a byte-array
// reference memory, with a word-wide memory model attached to the DUT's memory port.
module tb_dmem_access_unit;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] addr, write_data, read_data;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_access_unit #(.REG_BITS(32), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .write_data(write_data),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    // Data_Memory model attached to the DUT
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        mem_init;

    function automatic logic [31:0] seed_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= seed_word(i);
        end else if (MemWrite) begin
            mem[addr[7:0]] <= write_data;
        end
    end
    assign read_data = mem[addr[7:0]];

    // Bus monitor
    int          rd_tot = 0, wr_tot = 0;
    logic [31:0] last_wa = '0, last_wd = '0;
    bit          both_hi = 1'b0;
    always @(negedge clk) begin
        if (MemRead) rd_tot++;
        if (MemWrite) begin
            wr_tot++;
            last_wa = addr;
            last_wd = write_data;
        end
        if (MemRead && MemWrite) both_hi = 1'b1;
    end

    // Reference model: byte-addressed little-endian memory
    logic [7:0] ref_mem [0:4*MEM_WORDS-1];

    function automatic bit ref_err(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
               || ((a / 4) >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] sz, logic sg, logic [31:0] a);
        longint v  = 0;
        int     nb = 1 << sz;
        for (int i = 0; i < nb; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nb = 1 << sz;
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_word(logic [31:0] a);
        int b = int'(a) & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_xact(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] got_rd, output logic [31:0] got_wd);
        bit          e;
        int          exp_lat, exp_rn, exp_wn, lat, r0, w0, n;
        logic [31:0] exp_rd;
        logic        got_err;
        e       = ref_err(sz, a);
        exp_rd  = (!e && !w) ? ref_load(sz, sg, a) : 32'h0;
        exp_lat = e ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        exp_rn  = (!e && !(w && sz == 2'd2)) ? 1 : 0;
        exp_wn  = (!e && w) ? 1 : 0;
        if (!e && w) ref_store(sz, a, wd);

        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        r0 = rd_tot; w0 = wr_tot;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        lat = 0; got_rd = '0; got_err = 1'b0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            if (i > 1) begin
                @(posedge clk);
                #1;
            end
            if (resp_valid) begin
                lat = i; got_rd = resp_rdata; got_err = resp_err;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(got_err), 32'(e));
        check("rdata", got_rd, exp_rd);
        check("n_reads", 32'(rd_tot - r0), 32'(exp_rn));
        check("n_writes", 32'(wr_tot - w0), 32'(exp_wn));
        if (exp_wn == 1) begin
            check("wr_addr", last_wa, a >> 2);
            check("wr_data", last_wd, ref_word(a));
        end
        got_wd = last_wd;
        @(posedge clk);
        #1;
        check("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    logic [31:0] rd, wdo, hs_exp [3];
    int          acc_cyc [3];
    int          k, nresp, w_snap, seen_resp, bad;
    bit          acc;

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            logic [31:0] s;
            s = seed_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(s >> (8 * b));
        end
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0; reset = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_wdata", write_data, 32'd0);

        // Word store then load
        run_xact(1'b1, 2'd2, 1'b0, 32'h04, 32'hDEADBEEF, rd, wdo);
        check("t1_wdata", wdo, 32'hDEADBEEF);
        run_xact(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, wdo);
        check("t1_load", rd, 32'hDEADBEEF);

        // Byte RMW
        run_xact(1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344, rd, wdo);
        run_xact(1'b1, 2'd0, 1'b0, 32'h06, 32'h0000005A, rd, wdo);
        check("t2_rmw_wdata", wdo, 32'h115A3344);
        run_xact(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, wdo);
        check("t2_load", rd, 32'h115A3344);

        // Sign handling
        run_xact(1'b1, 2'd2, 1'b0, 32'h00, 32'h000080F0, rd, wdo);
        run_xact(1'b0, 2'd0, 1'b1, 32'h00, 32'h0, rd, wdo);
        check("t3_sbyte", rd, 32'hFFFFFFF0);
        run_xact(1'b0, 2'd0, 1'b0, 32'h00, 32'h0, rd, wdo);
        check("t3_ubyte", rd, 32'h000000F0);
        run_xact(1'b0, 2'd1, 1'b1, 32'h00, 32'h0, rd, wdo);
        check("t3_shalf", rd, 32'hFFFF80F0);

        // Errors
        run_xact(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, rd, wdo);
        run_xact(1'b1, 2'd2, 1'b0, 32'h02, 32'h12345678, rd, wdo);
        run_xact(1'b0, 2'd3, 1'b0, 32'h08, 32'h0, rd, wdo);
        run_xact(1'b0, 2'd2, 1'b0, 32'(MEM_WORDS * 4), 32'h0, rd, wdo);

        // Reset during the read phase of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        w_snap = wr_tot;
        check("t5_in_rd", 32'(MemRead), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_ready", 32'(req_ready), 32'd1);
        seen_resp = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) seen_resp++;
            @(posedge clk);
            #1;
        end
        check("t5_no_resp", 32'(seen_resp), 32'd0);
        check("t5_no_write", 32'(wr_tot - w_snap), 32'd0);
        check("t5_mem", mem[4], ref_word(32'h10));

        // Handshake with req_valid held high across three loads
        for (int j = 0; j < 3; j++) hs_exp[j] = ref_load(2'd2, 1'b0, 32'h20 + 32'(4 * j));
        k = 0; nresp = 0;
        for (int cyc = 0; cyc < 40 && nresp < 3; cyc++) begin
            @(negedge clk);
            if (k < 3) begin
                req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
                req_addr = 32'h20 + 32'(4 * k);
            end else begin
                req_valid = 1'b0;
            end
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                acc_cyc[k] = cyc;
                if (k > 0) check("hs_gap", 32'(cyc - acc_cyc[k-1]), 32'd3);
                k++;
            end
            if (resp_valid) begin
                if (nresp < 3) check("hs_data", resp_rdata, hs_exp[nresp]);
                nresp++;
            end
        end
        req_valid = 1'b0;
        check("hs_accepts", 32'(k), 32'd3);
        check("hs_resps", 32'(nresp), 32'd3);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0)
                a = (32'($urandom_range(MEM_WORDS, 4000)) << 2) | 32'($urandom_range(0, 3));
            else
                a = 32'($urandom_range(0, 127));
            run_xact(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, rd, wdo);
        end

        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== ref_word(32'(4 * i))) bad++;
        check("mem_final", 32'(bad), 32'd0);
        check("rd_wr_exclusive", 32'(both_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
